// File: rtl/show_sequencer_if.sv
// rtl/show_sequencer_if.sv - button/repeat inputs and show status outputs of the sequencer
interface show_sequencer_if;
  logic       startBtn;
  logic [3:0] repeatIn;
  logic       enable;
  logic       running;
  logic       done;
  logic [1:0] state;

  // Drives the sequencer inputs and observes its status
  modport master (
    output startBtn,
    output repeatIn,
    input  enable,
    input  running,
    input  done,
    input  state
  );

  // The sequencer itself
  modport slave (
    input  startBtn,
    input  repeatIn,
    output enable,
    output running,
    output done,
    output state
  );
endinterface

// File: rtl/show_sequencer.sv
// rtl/show_sequencer.sv - start-button debounce, run/pause/done FSM and frame-advance divider
module show_sequencer #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int FRAME_HZ        = 20,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic             clk,
  input  logic             resetBtn,
  show_sequencer_if.slave  bus
);

  localparam int TICK_DIV = CLK_HZ / FRAME_HZ;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Synchronizer and debouncer state (button is active-low, so idle level is 1)
  logic            sync1_q;
  logic            sync2_q;
  logic            db_level_q;
  logic            db_level_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            press_q;
  logic            press_d;

  // Show control state and registered outputs
  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic             enable_q;
  logic             running_q;
  logic             done_q;

  logic             div_wrap;
  logic             repeat_zero;

  // Two-flop synchronizer for the asynchronous pushbutton
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.startBtn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles;
  // a press pulse fires only on the released->pressed acceptance
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        press_d    = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  assign div_wrap    = (div_q == DIV_LAST);
  assign repeat_zero = (bus.repeatIn == 4'd0);

  // Show FSM with frame divider; the divider advances every RUN cycle, but an enable
  // pulse is only issued when the show stays in RUN, so leaving RUN never emits a new frame
  always_ff @(posedge clk or negedge resetBtn) begin
    if (!resetBtn) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (press_q) begin
            state_q   <= S_RUN;
            div_q     <= '0;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (repeat_zero) begin
            state_q   <= S_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (press_q) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end else begin
            enable_q <= div_wrap;
          end
        end
        S_PAUSE: begin
          if (press_q) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable  = enable_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_show_sequencer.sv
// tb/tb_show_sequencer.sv - scoreboard bench for show_sequencer
module tb_show_sequencer;
  logic clk = 1'b0;
  logic resetBtn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   sb[$];
  logic prev_en = 1'b0;
  int   c;
  int   e;

  show_sequencer_if sif();

  show_sequencer #(
    .CLK_HZ(100),
    .FRAME_HZ(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetBtn(resetBtn),
    .bus(sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Enable monitor: every pulse must be single-cycle and match the next expected cycle
  always @(negedge clk) begin
    if (sif.enable) begin
      check_eq("enable_width", int'(prev_en), 0);
      if (sb.size() == 0) check_eq("enable_unexpected", cyc, -1);
      else check_eq("enable_cycle", cyc, sb.pop_front());
    end
    prev_en = sif.enable;
  end

  initial begin
    resetBtn     = 1'b0;
    sif.startBtn = 1'b1;
    sif.repeatIn = 4'd9;
    wait_cyc(3);
    check_eq("reset_state", sif.state, 0);
    check_eq("reset_enable", sif.enable, 0);
    check_eq("reset_running", sif.running, 0);
    check_eq("reset_done", sif.done, 0);
    resetBtn = 1'b1;

    // Glitch of 3 cycles is filtered
    wait_cyc(2);
    sif.startBtn = 1'b0;
    wait_cyc(3);
    sif.startBtn = 1'b1;
    wait_cyc(12);
    check_eq("glitch_state", sif.state, 0);

    // Start: held press, RUN 7 edges after the falling input, frames every 10 cycles
    c = cyc;
    sif.startBtn = 1'b0;
    e = c + 7;
    sb.push_back(e + 10);
    sb.push_back(e + 20);
    sb.push_back(e + 30);
    wait_cyc(6);
    check_eq("start_pre_state", sif.state, 0);
    wait_cyc(1);
    check_eq("start_run_state", sif.state, 1);
    check_eq("start_running", sif.running, 1);
    wait_until(c + 20);
    sif.startBtn = 1'b1;

    // Pause: press pulse lands while the divider holds 6
    wait_until(e + 30);
    c = cyc;
    sif.startBtn = 1'b0;
    wait_cyc(7);
    check_eq("pause_state", sif.state, 2);
    check_eq("pause_running", sif.running, 0);
    wait_cyc(1);
    sif.startBtn = 1'b1;
    wait_cyc(25);
    check_eq("pause_hold", sif.state, 2);

    // Resume: divider continues, first frame 3 RUN cycles later
    c = cyc;
    sif.startBtn = 1'b0;
    sb.push_back(c + 10);
    sb.push_back(c + 20);
    wait_cyc(7);
    check_eq("resume_state", sif.state, 1);
    wait_cyc(1);
    sif.startBtn = 1'b1;
    wait_until(c + 20);

    // Asynchronous reset mid-cycle while an enable pulse is high
    #2;
    resetBtn = 1'b0;
    #1;
    check_eq("async_rst_state", sif.state, 0);
    check_eq("async_rst_enable", sif.enable, 0);
    check_eq("async_rst_running", sif.running, 0);
    check_eq("async_rst_done", sif.done, 0);
    check_eq("sb_drain_resume", sb.size(), 0);
    @(negedge clk);
    resetBtn = 1'b1;

    // Done: repeatIn reaches 0 in RUN
    wait_cyc(2);
    c = cyc;
    sif.startBtn = 1'b0;
    e = c + 7;
    sb.push_back(e + 10);
    wait_cyc(8);
    sif.startBtn = 1'b1;
    wait_until(e + 15);
    sif.repeatIn = 4'd0;
    wait_cyc(1);
    check_eq("done_state", sif.state, 3);
    check_eq("done_flag", sif.done, 1);
    check_eq("done_running", sif.running, 0);
    wait_cyc(2);
    sif.startBtn = 1'b0;
    wait_cyc(10);
    sif.startBtn = 1'b1;
    wait_cyc(10);
    check_eq("done_absorb", sif.state, 3);
    resetBtn = 1'b0;
    wait_cyc(1);
    check_eq("done_reset_state", sif.state, 0);
    check_eq("done_reset_flag", sif.done, 0);
    resetBtn = 1'b1;
    wait_cyc(5);
    check_eq("idle_ignores_repeat", sif.state, 0);
    sif.repeatIn = 4'd9;

    // Collision: press pulse and repeatIn==0 in the same RUN cycle
    wait_cyc(1);
    c = cyc;
    sif.startBtn = 1'b0;
    e = c + 7;
    sb.push_back(e + 10);
    wait_cyc(8);
    sif.startBtn = 1'b1;
    wait_until(e + 12);
    sif.startBtn = 1'b0;
    wait_cyc(6);
    sif.repeatIn = 4'd0;
    wait_cyc(1);
    check_eq("collide_state", sif.state, 3);
    check_eq("collide_enable", sif.enable, 0);
    sif.startBtn = 1'b1;
    wait_cyc(5);
    check_eq("sb_drain_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
